dma_engine: RTL and testbench
=============================

Name: dma_engine

Overview:
- Bus initiator that drives the same CPU-side memory/MMIO bus the CPU uses, and copies a block from a source address to a destination address.
- It issues one read followed by one write per element, and honours the responder-side wait signal.
- The CPU configures it through a small register port; arbitration with the CPU is a req/gnt pair.
- It sits beside the CPU core at the memory arbiter, acting as a second bus master.

Parameters:
- CNT_W, 16, width of the element counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low: state is cleared on a clk edge while rst==0
- cfg_wr  in  1  config write strobe
- cfg_sel  in  2  register select: 0 src, 1 dst, 2 count, 3 ctrl
- cfg_data  in  16  config write data
- busy  out  1  transfer in progress
- done  out  1  sticky completion flag
- aborted  out  1  sticky abort flag
- irq  out  1  one-cycle pulse on completion or abort
- bus_req  out  1  bus request to arbiter
- bus_gnt  in  1  bus grant from arbiter
- bus_en  out  1  transaction valid
- bus_we  out  1  1 = write, 0 = read
- bus_byte_select  out  1  low address bit (real address = {bus_addr[14:0], bus_byte_select})
- bus_byte_enable  out  1  1 = byte access
- bus_addr  out  16  word address
- bus_wdata  out  16  write data
- bus_rdata  in  16  read data, valid the cycle after the read beat
- bus_wait  in  1  responder stall; hold the current beat while high

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: busy, done, aborted, irq, bus_req, bus_en, bus_we, bus_byte_select, bus_byte_enable, bus_addr, bus_wdata.
  - Registers are cleared: src, dst, count, data buffer.
  - Reset mid-transfer abandons the transfer immediately, with no completion of the current beat.
- Config writes:
  - Writes to src, dst or count while busy==1 are ignored.
  - ctrl bit0 = start, bit1 = byte mode, bit2 = abort.
  - Start while busy is ignored. Abort while idle is ignored.
- Start:
  - Clears done and aborted and latches the mode.
  - If count==0: go straight to FIN without any bus beat. done=1 and irq pulses, 1 cycle after the start write.
- Address mapping:
  - Word mode: bus_addr = ptr, bus_byte_select = 0, bus_byte_enable = 0; ptr increments by 1.
  - Byte mode: bus_addr = {1'b0, ptr[15:1]}, bus_byte_select = ptr[0], bus_byte_enable = 1; ptr increments by 1.
  - Pointers wrap 16'hFFFF -> 16'h0000 silently.
- State machine:
  - IDLE: bus_req=0. Start -> REQ.
  - REQ: busy=1, bus_req=1. Go to RD when bus_gnt==1. Abort seen here -> FIN(abort).
  - RD: bus_en=1, bus_we=0, addr from src_ptr. Held while bus_wait==1; when bus_wait==0 -> CAP.
  - CAP: bus_en=0. Latch bus_rdata into the buffer (byte mode keeps bits [7:0], upper bits zeroed) -> WR.
  - WR: bus_en=1, bus_we=1, bus_wdata=buffer, addr from dst_ptr. Held while bus_wait==1. On completion: src_ptr++, dst_ptr++, count--. Then:
    - count was 1 -> FIN(done);
    - else if abort pending -> FIN(abort);
    - else if bus_gnt==0 -> REQ;
    - else -> RD.
  - FIN: bus_req=0, busy=0, irq=1 for one cycle; set done or aborted -> IDLE.
- Throughput: 3 cycles per element with no wait states and grant held.
- Abort semantics:
  - Abort is latched as pending and acts only at an element boundary (end of WR) or in REQ.
  - A beat in flight always completes.
  - Completion takes priority over abort on the last element.
- bus_gnt drop mid-beat is illegal; the arbiter only revokes the grant while bus_en==0.
- Readable state: src, dst and count registers reflect the live pointers and remaining count. Their read-back path lives in the existing MMIO responder and is outside this block.

Decomposition:
- Shared header cpu_constants.vh holds:
  - DMA cfg_sel offsets (DMA_SRC, DMA_DST, DMA_CNT, DMA_CTRL);
  - ctrl bit indices;
  - state encodings (IDLE, REQ, RD, CAP, WR, FIN).
- One sub-module, dma_cfg_regs: holds the config registers, the busy-gated write logic and the abort-pending latch.
- dma_engine keeps the FSM and the bus datapath.

Test Plan:
- Word copy: src=0x0100, dst=0x0200, count=3, gnt tied 1, no wait.
  - Expect 3 reads then 3 writes in order: read 0x0100 -> write 0x0200, read 0x0101 -> write 0x0201, read 0x0102 -> write 0x0202.
  - Data matches; done=1 and irq pulse at cycle 1+1+9; busy falls in the same cycle.
- Byte mode: src=0xFF03 (UART status), dst=0x0011, count=1.
  - Read beat bus_addr=0x7F81, byte_select=1, byte_enable=1.
  - Write beat bus_addr=0x0008, byte_select=1, wdata = {8'h00, rdata[7:0]}.
- Wait states: bus_wait high for 4 cycles during the second WR.
  - bus_en, bus_addr and bus_wdata stay stable for all 4 cycles; count decrements only after bus_wait falls.
- Zero count and pointer wrap:
  - count=0: no bus_en at all; done and irq 1 cycle after start.
  - src=0xFFFF, count=2: second read at 0x0000.
- Abort:
  - Abort written during RD of element 1 of 5: that element's write completes, then FIN.
  - aborted=1, done=0, count reads 4.
  - Subsequent writes to src while idle are accepted.
- Grant and reset:
  - bus_gnt held 0 for 6 cycles: stays in REQ with bus_en=0.
  - rst=0 mid-WR: next cycle all outputs are 0 and state is IDLE.
  - Start write while busy is ignored.

Source files
------------

// File: rtl/dma_engine_pkg.sv
// Shared definitions for the DMA engine: register offsets, ctrl bit positions,
// FSM state encoding and the pointer-to-bus address mapping helper.
package dma_engine_pkg;

    // cfg_sel register offsets
    localparam logic [1:0] DMA_SRC  = 2'd0;
    localparam logic [1:0] DMA_DST  = 2'd1;
    localparam logic [1:0] DMA_CNT  = 2'd2;
    localparam logic [1:0] DMA_CTRL = 2'd3;

    // ctrl register bit indices
    localparam int CTRL_START = 0;
    localparam int CTRL_BYTE  = 1;
    localparam int CTRL_ABORT = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4,
        ST_FIN  = 3'd5
    } dma_state_e;

    // Bus-side view of a pointer: word address plus byte lane controls
    typedef struct packed {
        logic [15:0] addr;
        logic        byte_sel;
        logic        byte_en;
    } bus_loc_t;

    localparam bus_loc_t LOC_IDLE = '{addr: 16'h0000, byte_sel: 1'b0, byte_en: 1'b0};

    // Byte mode splits the pointer into word address and lane select;
    // word mode uses the pointer directly as the word address.
    function automatic bus_loc_t map_ptr(input logic [15:0] ptr, input logic byte_mode);
        bus_loc_t loc;
        if (byte_mode) begin
            loc.addr     = {1'b0, ptr[15:1]};
            loc.byte_sel = ptr[0];
            loc.byte_en  = 1'b1;
        end else begin
            loc.addr     = ptr;
            loc.byte_sel = 1'b0;
            loc.byte_en  = 1'b0;
        end
        return loc;
    endfunction

endpackage

// File: rtl/dma_cfg_regs.sv
// DMA configuration registers: source/destination pointers, remaining count,
// latched transfer mode and the abort-pending latch. Pointer/count writes are
// blocked while a transfer runs; during a transfer they advance per element.
module dma_cfg_regs
    import dma_engine_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cfg_wr,
    input  logic [1:0]       i_cfg_sel,
    input  logic [15:0]      i_cfg_data,
    input  logic             i_busy,
    input  logic             i_fin,
    input  logic             i_elem_done,
    output logic [15:0]      o_src,
    output logic [15:0]      o_dst,
    output logic [CNT_W-1:0] o_count,
    output logic             o_byte_mode,
    output logic             o_start,
    output logic             o_abort
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [15:0]      r_src;
    logic [15:0]      r_dst;
    logic [CNT_W-1:0] r_count;
    logic             r_byte_mode;
    logic             r_abort_pend;

    logic w_ctrl_wr;
    logic w_reg_wr;
    logic w_abort_wr;

    assign w_ctrl_wr  = i_cfg_wr && (i_cfg_sel == DMA_CTRL);
    assign w_reg_wr   = i_cfg_wr && !i_busy;
    assign w_abort_wr = w_ctrl_wr && i_cfg_data[CTRL_ABORT] && i_busy;

    assign o_start     = w_ctrl_wr && i_cfg_data[CTRL_START] && !i_busy;
    // A live abort write counts immediately so it is not lost on the boundary cycle
    assign o_abort     = r_abort_pend || w_abort_wr;
    assign o_src       = r_src;
    assign o_dst       = r_dst;
    assign o_count     = r_count;
    assign o_byte_mode = r_byte_mode;

    // Config register writes (idle only) and per-element pointer/count advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_src        <= 16'h0000;
            r_dst        <= 16'h0000;
            r_count      <= '0;
            r_byte_mode  <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            if (w_reg_wr && (i_cfg_sel == DMA_SRC)) begin
                r_src <= i_cfg_data;
            end else if (i_elem_done) begin
                r_src <= r_src + 16'd1;
            end else begin
                r_src <= r_src;
            end

            if (w_reg_wr && (i_cfg_sel == DMA_DST)) begin
                r_dst <= i_cfg_data;
            end else if (i_elem_done) begin
                r_dst <= r_dst + 16'd1;
            end else begin
                r_dst <= r_dst;
            end

            if (w_reg_wr && (i_cfg_sel == DMA_CNT)) begin
                r_count <= CNT_W'(i_cfg_data);
            end else if (i_elem_done) begin
                r_count <= r_count - CNT_ONE;
            end else begin
                r_count <= r_count;
            end

            if (o_start) begin
                r_byte_mode <= i_cfg_data[CTRL_BYTE];
            end else begin
                r_byte_mode <= r_byte_mode;
            end

            // Pending abort is consumed by FIN and discarded by a fresh start
            if (o_start || i_fin) begin
                r_abort_pend <= 1'b0;
            end else if (w_abort_wr) begin
                r_abort_pend <= 1'b1;
            end else begin
                r_abort_pend <= r_abort_pend;
            end
        end
    end

endmodule

// File: rtl/dma_engine.sv
// DMA bus initiator: copies count elements from src to dst, one read beat
// followed by one write beat per element, sharing the CPU bus via req/gnt.
// All bus and status outputs are registered and decoded from the next state.
module dma_engine
    import dma_engine_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_sel,
    input  logic [15:0] cfg_data,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        irq,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_en,
    output logic        bus_we,
    output logic        bus_byte_select,
    output logic        bus_byte_enable,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_wait
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dma_state_e r_state;
    dma_state_e w_next;

    logic             w_busy;
    logic             w_fin;
    logic             w_elem_done;
    logic             w_start;
    logic             w_abort;
    logic             w_byte_mode;
    logic             w_set_done;
    logic             w_set_abort;
    logic [15:0]      w_src;
    logic [15:0]      w_dst;
    logic [15:0]      w_src_ptr;
    logic [CNT_W-1:0] w_count;
    logic [15:0]      w_buf_next;
    bus_loc_t         w_loc_next;

    logic [15:0] r_buf;
    logic        r_busy;
    logic        r_done;
    logic        r_aborted;
    logic        r_irq;
    logic        r_bus_req;
    logic        r_bus_en;
    logic        r_bus_we;
    logic        r_bus_byte_select;
    logic        r_bus_byte_enable;
    logic [15:0] r_bus_addr;
    logic [15:0] r_bus_wdata;

    assign w_busy      = (r_state == ST_REQ) || (r_state == ST_RD) ||
                         (r_state == ST_CAP) || (r_state == ST_WR);
    assign w_fin       = (r_state == ST_FIN);
    assign w_elem_done = (r_state == ST_WR) && !bus_wait;
    // Next read after a completed write already uses the advanced source pointer
    assign w_src_ptr   = w_elem_done ? (w_src + 16'd1) : w_src;

    dma_cfg_regs #(
        .CNT_W (CNT_W)
    ) u_cfg (
        .clk         (clk),
        .rst         (rst),
        .i_cfg_wr    (cfg_wr),
        .i_cfg_sel   (cfg_sel),
        .i_cfg_data  (cfg_data),
        .i_busy      (w_busy),
        .i_fin       (w_fin),
        .i_elem_done (w_elem_done),
        .o_src       (w_src),
        .o_dst       (w_dst),
        .o_count     (w_count),
        .o_byte_mode (w_byte_mode),
        .o_start     (w_start),
        .o_abort     (w_abort)
    );

    // Next-state decode plus done/abort completion decisions
    always_comb begin
        w_next      = r_state;
        w_set_done  = 1'b0;
        w_set_abort = 1'b0;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (w_start) begin
                    if (w_count == CNT_ZERO) begin
                        w_next     = ST_FIN;
                        w_set_done = 1'b1;
                    end else begin
                        w_next = ST_REQ;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_abort) begin
                    w_next      = ST_FIN;
                    w_set_abort = 1'b1;
                end else if (bus_gnt) begin
                    w_next = ST_RD;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_RD: begin
                if (!bus_wait) begin
                    w_next = ST_CAP;
                end else begin
                    w_next = ST_RD;
                end
            end
            ST_CAP: begin
                w_next = ST_WR;
            end
            ST_WR: begin
                if (bus_wait) begin
                    w_next = ST_WR;
                end else if (w_count == CNT_ONE) begin
                    // Last element wins over a pending abort
                    w_next     = ST_FIN;
                    w_set_done = 1'b1;
                end else if (w_abort) begin
                    w_next      = ST_FIN;
                    w_set_abort = 1'b1;
                end else if (!bus_gnt) begin
                    w_next = ST_REQ;
                end else begin
                    w_next = ST_RD;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Read data capture value and bus location for the upcoming beat
    always_comb begin
        w_buf_next = r_buf;
        w_loc_next = LOC_IDLE;
        if (r_state == ST_CAP) begin
            if (w_byte_mode) begin
                w_buf_next = {8'h00, bus_rdata[7:0]};
            end else begin
                w_buf_next = bus_rdata;
            end
        end else begin
            w_buf_next = r_buf;
        end
        if (w_next == ST_RD) begin
            w_loc_next = map_ptr(w_src_ptr, w_byte_mode);
        end else if (w_next == ST_WR) begin
            w_loc_next = map_ptr(w_dst, w_byte_mode);
        end else begin
            w_loc_next = LOC_IDLE;
        end
    end

    // State register, data buffer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= ST_IDLE;
            r_buf             <= 16'h0000;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_aborted         <= 1'b0;
            r_irq             <= 1'b0;
            r_bus_req         <= 1'b0;
            r_bus_en          <= 1'b0;
            r_bus_we          <= 1'b0;
            r_bus_byte_select <= 1'b0;
            r_bus_byte_enable <= 1'b0;
            r_bus_addr        <= 16'h0000;
            r_bus_wdata       <= 16'h0000;
        end else begin
            r_state           <= w_next;
            r_buf             <= w_buf_next;
            r_busy            <= (w_next == ST_REQ) || (w_next == ST_RD) ||
                                 (w_next == ST_CAP) || (w_next == ST_WR);
            r_bus_req         <= (w_next == ST_REQ) || (w_next == ST_RD) ||
                                 (w_next == ST_CAP) || (w_next == ST_WR);
            r_irq             <= (w_next == ST_FIN);
            r_bus_en          <= (w_next == ST_RD) || (w_next == ST_WR);
            r_bus_we          <= (w_next == ST_WR);
            r_bus_byte_select <= w_loc_next.byte_sel;
            r_bus_byte_enable <= w_loc_next.byte_en;
            r_bus_addr        <= w_loc_next.addr;
            r_bus_wdata       <= (w_next == ST_WR) ? w_buf_next : 16'h0000;

            if (w_start) begin
                r_done <= w_set_done;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end else begin
                r_done <= r_done;
            end

            if (w_start) begin
                r_aborted <= 1'b0;
            end else if (w_set_abort) begin
                r_aborted <= 1'b1;
            end else begin
                r_aborted <= r_aborted;
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign aborted         = r_aborted;
    assign irq             = r_irq;
    assign bus_req         = r_bus_req;
    assign bus_en          = r_bus_en;
    assign bus_we          = r_bus_we;
    assign bus_byte_select = r_bus_byte_select;
    assign bus_byte_enable = r_bus_byte_enable;
    assign bus_addr        = r_bus_addr;
    assign bus_wdata       = r_bus_wdata;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: table of single-element transfers plus
// directed sequences for multi-element, wait, abort, grant and reset cases.
module tb_dma_engine;
    import dma_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [15:0] cfg_data = 16'h0000;
    logic        busy, done, aborted, irq, bus_req;
    logic        bus_gnt = 1'b1;
    logic        bus_en, bus_we, bus_byte_select, bus_byte_enable;
    logic [15:0] bus_addr, bus_wdata;
    logic [15:0] bus_rdata = 16'h0000;
    logic        bus_wait = 1'b0;

    always #5 clk = ~clk;

    dma_engine #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .busy(busy), .done(done), .aborted(aborted), .irq(irq), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .bus_en(bus_en), .bus_we(bus_we),
        .bus_byte_select(bus_byte_select), .bus_byte_enable(bus_byte_enable),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_wait(bus_wait)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic        bs;
        logic        be;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic        byte_m;
        logic [15:0] rd_addr;
        logic        rd_bs;
        logic        be;
        logic [15:0] wr_addr;
        logic        wr_bs;
        logic [15:0] wdata;
    } vec_t;

    beat_t log_q[$];
    vec_t  vecs[5];
    int    n_cmp = 0;
    int    n_err = 0;

    // Responder model: log completed beats, return {C3, addr[6:0], lane} for reads
    always @(negedge clk) begin
        beat_t b;
        if (rst && bus_en && !bus_wait) begin
            b.we = bus_we; b.addr = bus_addr; b.bs = bus_byte_select;
            b.be = bus_byte_enable; b.wdata = bus_wdata;
            log_q.push_back(b);
            if (!bus_we) bus_rdata = {8'hC3, bus_addr[6:0], bus_byte_select};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] d);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_sel = sel; cfg_data = d;
        @(posedge clk); #1;
        cfg_wr = 1'b0; cfg_data = 16'h0000;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
        cfg_write(DMA_SRC, s);
        cfg_write(DMA_DST, d);
        cfg_write(DMA_CNT, c);
    endtask

    task automatic start(input logic byte_m);
        log_q.delete();
        cfg_write(DMA_CTRL, {13'd0, 1'b0, byte_m, 1'b1});
    endtask

    // Number of negedges (first one in the current cycle) until irq, -1 on timeout
    task automatic wait_irq(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (irq) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic chk_beat(input string nm, input int idx, input logic we, input logic [15:0] a,
                            input logic bs, input logic be, input logic [15:0] wd);
        chk({nm, "_present"}, 64'(log_q.size() > idx), 64'(1));
        if (log_q.size() > idx)
            chk(nm, 64'({log_q[idx].we, log_q[idx].addr, log_q[idx].bs, log_q[idx].be, log_q[idx].wdata}),
                64'({we, a, bs, be, wd}));
    endtask

    initial begin
        int k;
        vecs[0] = '{src:16'h0100, dst:16'h0200, byte_m:1'b0, rd_addr:16'h0100, rd_bs:1'b0, be:1'b0,
                    wr_addr:16'h0200, wr_bs:1'b0, wdata:16'hC300};
        vecs[1] = '{src:16'hFF03, dst:16'h0011, byte_m:1'b1, rd_addr:16'h7F81, rd_bs:1'b1, be:1'b1,
                    wr_addr:16'h0008, wr_bs:1'b1, wdata:16'h0003};
        vecs[2] = '{src:16'h1234, dst:16'hFFFE, byte_m:1'b1, rd_addr:16'h091A, rd_bs:1'b0, be:1'b1,
                    wr_addr:16'h7FFF, wr_bs:1'b0, wdata:16'h0034};
        vecs[3] = '{src:16'hFFFF, dst:16'h8000, byte_m:1'b0, rd_addr:16'hFFFF, rd_bs:1'b0, be:1'b0,
                    wr_addr:16'h8000, wr_bs:1'b0, wdata:16'hC3FE};
        vecs[4] = '{src:16'h00AA, dst:16'h5555, byte_m:1'b0, rd_addr:16'h00AA, rd_bs:1'b0, be:1'b0,
                    wr_addr:16'h5555, wr_bs:1'b0, wdata:16'hC354};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({busy, done, aborted, irq, bus_req, bus_en, bus_we, bus_byte_select,
                                  bus_byte_enable, bus_addr, bus_wdata}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Table: single-element transfers, address mapping and data path
        for (int v = 0; v < 5; v++) begin
            setup(vecs[v].src, vecs[v].dst, 16'd1);
            start(vecs[v].byte_m);
            wait_irq(k);
            chk($sformatf("vec%0d_irq_cycle", v), 64'(k), 64'(5));
            chk($sformatf("vec%0d_fin_flags", v), 64'({busy, done, aborted}), 64'(3'b010));
            chk($sformatf("vec%0d_beats", v), 64'(log_q.size()), 64'(2));
            chk_beat($sformatf("vec%0d_rd", v), 0, 1'b0, vecs[v].rd_addr, vecs[v].rd_bs, vecs[v].be, 16'h0000);
            chk_beat($sformatf("vec%0d_wr", v), 1, 1'b1, vecs[v].wr_addr, vecs[v].wr_bs, vecs[v].be, vecs[v].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_irq_pulse", v), 64'({irq, done}), 64'(2'b01));
        end

        // Word copy of 3 elements: done cleared on start, FIN at cycle 11
        setup(16'h0100, 16'h0200, 16'd3);
        start(1'b0);
        @(negedge clk);
        chk("copy3_started", 64'({busy, bus_req, done}), 64'(3'b110));
        wait_irq(k);
        chk("copy3_irq_cycle", 64'(k), 64'(10));
        chk("copy3_fin_flags", 64'({busy, done, aborted}), 64'(3'b010));
        chk("copy3_beats", 64'(log_q.size()), 64'(6));
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("copy3_rd%0d", i), 2 * i, 1'b0, 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0000);
            chk_beat($sformatf("copy3_wr%0d", i), 2 * i + 1, 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0,
                     16'hC300 + 16'(2 * i));
        end

        // Wait states: 4 stalled cycles on the second write
        setup(16'h0300, 16'h0400, 16'd3);
        start(1'b0);
        repeat (6) @(posedge clk);
        #1 bus_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("wait_hold%0d", i), 64'({bus_en, bus_we, bus_addr, bus_wdata}),
                64'({1'b1, 1'b1, 16'h0401, 16'hC302}));
            chk($sformatf("wait_count%0d", i), 64'(dut.w_count), 64'(2));
        end
        @(posedge clk); #1 bus_wait = 1'b0;
        @(negedge clk);
        chk("wait_release_count", 64'(dut.w_count), 64'(2));
        @(negedge clk);
        chk("wait_after_count", 64'(dut.w_count), 64'(1));
        wait_irq(k);
        chk("wait_irq_cycle", 64'(k), 64'(3));
        chk("wait_beats", 64'(log_q.size()), 64'(6));

        // Pointer wrap
        setup(16'hFFFF, 16'h0010, 16'd2);
        start(1'b0);
        wait_irq(k);
        chk("wrap_irq_cycle", 64'(k), 64'(8));
        chk_beat("wrap_rd0", 0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
        chk_beat("wrap_rd1", 2, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk_beat("wrap_wr1", 3, 1'b1, 16'h0011, 1'b0, 1'b0, 16'hC300);

        // Abort during RD of element 1 of 5
        setup(16'h0500, 16'h0600, 16'd5);
        start(1'b0);
        cfg_write(DMA_CTRL, 16'h0004);
        wait_irq(k);
        chk("abort_irq_cycle", 64'(k), 64'(3));
        chk("abort_flags", 64'({busy, done, aborted}), 64'(3'b001));
        chk("abort_count", 64'(dut.w_count), 64'(4));
        chk("abort_beats", 64'(log_q.size()), 64'(2));
        chk_beat("abort_wr", 1, 1'b1, 16'h0600, 1'b0, 1'b0, 16'hC300);
        cfg_write(DMA_SRC, 16'h0ABC);
        chk("abort_src_wr", 64'(dut.w_src), 64'(16'h0ABC));
        cfg_write(DMA_CTRL, 16'h0004);
        chk("idle_abort_ignored", 64'(dut.u_cfg.r_abort_pend), 64'(0));

        // Zero count: FIN one cycle after start, no beats
        setup(16'h0ABC, 16'h0B00, 16'd0);
        start(1'b0);
        wait_irq(k);
        chk("zero_irq_cycle", 64'(k), 64'(1));
        chk("zero_flags", 64'({busy, done, aborted}), 64'(3'b010));
        chk("zero_beats", 64'(log_q.size()), 64'(0));

        // Grant withheld for 6 cycles; start/count writes while busy ignored
        bus_gnt = 1'b0;
        setup(16'h0700, 16'h0800, 16'd1);
        start(1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("nogrant%0d", i), 64'({busy, bus_req, bus_en}), 64'(3'b110));
        end
        cfg_write(DMA_CNT, 16'd9);
        cfg_write(DMA_CTRL, 16'h0001);
        chk("busy_cnt_ignored", 64'(dut.w_count), 64'(1));
        bus_gnt = 1'b1;
        wait_irq(k);
        chk("grant_completed", 64'(k > 0), 64'(1));
        chk("grant_beats", 64'(log_q.size()), 64'(2));
        chk_beat("grant_wr", 1, 1'b1, 16'h0800, 1'b0, 1'b0, 16'hC300);

        // Reset in the middle of the first write
        setup(16'h0900, 16'h0A00, 16'd3);
        start(1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midwr_is_write", 64'({bus_en, bus_we}), 64'(2'b11));
        @(negedge clk);
        chk("midwr_rst_outputs", 64'({busy, done, aborted, irq, bus_req, bus_en, bus_we, bus_byte_select,
                                      bus_byte_enable, bus_addr, bus_wdata}), 64'(0));
        chk("midwr_rst_state", 64'(dut.r_state == ST_IDLE), 64'(1));
        chk("midwr_rst_regs", 64'({dut.w_src, dut.w_dst, dut.w_count, dut.r_buf}), 64'(0));
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
